// File: rtl/elevator_car_ctrl_if.sv
// Dispatcher <-> car controller signal bundle.
// The dispatcher side is the master; the car controller is the slave.
interface elevator_car_ctrl_if;
  logic [13:0] hallButton;
  logic [6:0]  carButtonPress;
  logic [2:0]  currentFloor;
  logic [1:0]  direction;
  logic        doorOpen;
  logic [6:0]  carButton;
  logic [13:0] servedHall;

  modport master (
    output hallButton, carButtonPress,
    input  currentFloor, direction, doorOpen, carButton, servedHall
  );

  modport slave (
    input  hallButton, carButtonPress,
    output currentFloor, direction, doorOpen, carButton, servedHall
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Per-car motion/door controller for a 7-floor elevator.
// Moves floor by floor, opens the door at serviced floors, latches in-car
// requests and pulses servedHall to clear hall calls at the dispatcher.
module elevator_car_ctrl #(
  parameter int unsigned FLOOR_TICKS = 100,
  parameter int unsigned DOOR_TICKS  = 50
) (
  input  logic               clk,
  input  logic               reset,
  elevator_car_ctrl_if.slave bus
);
  localparam int unsigned   TMAX       = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned   TW         = $clog2(TMAX);
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;
  typedef enum logic [1:0] {DIR_STOP = 2'b00, DIR_UP = 2'b10, DIR_DOWN = 2'b01} dir_e;

  state_e        state_q;
  dir_e          dir_q;
  dir_e          last_dir_q;
  logic [2:0]    floor_q;
  logic          door_q;
  logic [6:0]    car_q;
  logic [13:0]   served_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    keep_q;     // hall bits {UP,DOWN} this stop is serving

  logic [2:0]    cur_idx;
  logic [13:0]   cur_pair;
  logic [13:0]   hall_eff;
  logic [6:0]    car_eff;
  logic [6:0]    req_vec;
  logic          req_above;
  logic          req_below;
  dir_e          idle_dir;
  logic          going_up;
  logic [2:0]    floor_d;
  logic [2:0]    nxt_idx;
  logic [1:0]    hall_nxt;
  logic [1:0]    hall_cur;
  logic          beyond_nxt;
  logic          stop_nxt;
  logic [1:0]    keep_nxt;

  // Request view for the current floor and the stop decision for the next floor.
  always_comb begin
    cur_idx  = floor_q - 3'd1;
    cur_pair = 14'h3 << {cur_idx, 1'b0};
    // Hall bits at our floor still read set while the dispatcher is clearing them.
    hall_eff = (served_q != '0) ? (bus.hallButton & ~cur_pair) : bus.hallButton;
    car_eff  = car_q | bus.carButtonPress;
    req_vec  = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      req_vec[i] = car_eff[i] | hall_eff[2*i] | hall_eff[2*i+1];
    end
    req_above = |(req_vec & (7'h7F << (cur_idx + 3'd1)));
    req_below = |(req_vec & ~(7'h7F << cur_idx));
    if (req_above && req_below) idle_dir = last_dir_q;
    else if (req_above)         idle_dir = DIR_UP;
    else                        idle_dir = DIR_DOWN;

    going_up = (dir_q == DIR_UP);
    if (going_up) floor_d = (floor_q == 3'd7) ? 3'd7 : floor_q + 3'd1;
    else          floor_d = (floor_q == 3'd1) ? 3'd1 : floor_q - 3'd1;
    nxt_idx    = floor_d - 3'd1;
    hall_nxt   = hall_eff[{nxt_idx, 1'b0} +: 2];
    hall_cur   = hall_eff[{cur_idx, 1'b0} +: 2];
    beyond_nxt = going_up ? |(req_vec & (7'h7F << (nxt_idx + 3'd1)))
                          : |(req_vec & ~(7'h7F << nxt_idx));
    stop_nxt   = car_eff[nxt_idx]
               | (going_up ? hall_nxt[1] : hall_nxt[0])
               | (!beyond_nxt & req_vec[nxt_idx])
               | (going_up ? (floor_d == 3'd7) : (floor_d == 3'd1));
    keep_nxt   = (going_up ? 2'b10 : 2'b01) | (beyond_nxt ? 2'b00 : 2'b11);
  end

  // Car FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_STOP;
      last_dir_q <= DIR_UP;
      floor_q    <= 3'd1;
      door_q     <= 1'b0;
      car_q      <= '0;
      served_q   <= '0;
      timer_q    <= '0;
      keep_q     <= '0;
    end else begin
      served_q <= '0;
      case (state_q)
        IDLE: begin
          car_q <= car_eff;
          if (req_vec[cur_idx]) begin
            state_q  <= DOOR_OPEN;
            door_q   <= 1'b1;
            timer_q  <= DOOR_LOAD;
            car_q    <= car_eff & ~(7'd1 << cur_idx);
            served_q <= cur_pair;
            keep_q   <= 2'b11;
          end else if (req_above || req_below) begin
            state_q    <= MOVING;
            timer_q    <= FLOOR_LOAD;
            dir_q      <= idle_dir;
            last_dir_q <= idle_dir;
          end
        end
        MOVING: begin
          car_q <= car_eff;
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            floor_q <= floor_d;
            if (stop_nxt) begin
              state_q  <= DOOR_OPEN;
              door_q   <= 1'b1;
              timer_q  <= DOOR_LOAD;
              car_q    <= car_eff & ~(7'd1 << nxt_idx);
              keep_q   <= keep_nxt;
              served_q <= {12'd0, keep_nxt & hall_nxt} << {nxt_idx, 1'b0};
              if (!beyond_nxt) last_dir_q <= going_up ? DIR_DOWN : DIR_UP;
            end else begin
              timer_q <= FLOOR_LOAD;
            end
          end
        end
        DOOR_OPEN: begin
          car_q <= car_eff & ~(7'd1 << cur_idx);
          if ((|(hall_cur & keep_q)) || bus.carButtonPress[cur_idx]) begin
            timer_q  <= DOOR_LOAD;
            served_q <= {12'd0, hall_cur & keep_q} << {cur_idx, 1'b0};
          end else if (timer_q == '0) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
            dir_q   <= DIR_STOP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.currentFloor = floor_q;
  assign bus.direction    = dir_q;
  assign bus.doorOpen     = door_q;
  assign bus.carButton    = car_q;
  assign bus.servedHall   = served_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios plus random hall/car traffic,
// checked every cycle against a floor-level behavioural model of the car.
module tb_elevator_car_ctrl;
  localparam int FT = 5;
  localparam int DT = 6;
  localparam int REST = 0, TRAVEL = 1, DWELL = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_car_ctrl_if bus ();
  elevator_car_ctrl #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (.clk(clk), .reset(reset), .bus(bus));

  // model state: floor as integer, direction as +1/-1/0, dwell/travel countdowns
  int          m_floor, m_dir, m_last, m_mode, m_cnt;
  bit          m_door, m_keep_up, m_keep_dn;
  logic [6:0]  m_car;
  logic [13:0] m_served;

  logic [13:0] hall_reg;
  logic [6:0]  press;
  logic        rst_drv;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit want(logic [6:0] c, logic [13:0] h, int f);
    return c[f-1] | h[2*f-1] | h[2*f-2];
  endfunction

  function automatic bit want_range(logic [6:0] c, logic [13:0] h, int lo, int hi);
    for (int f = lo; f <= hi; f++) if (want(c, h, f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] dir_code(int d);
    return (d > 0) ? 2'b10 : (d < 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic model_step(input logic rst, input logic [13:0] h, input logic [6:0] p);
    logic [6:0]  ce;
    logic [13:0] hm;
    bit ab, bl, beyond, hd, lim, hu, hdn;
    int nf;
    if (rst) begin
      m_floor = 1; m_dir = 0; m_last = 1; m_mode = REST; m_cnt = 0;
      m_door = 0; m_keep_up = 0; m_keep_dn = 0; m_car = '0; m_served = '0;
      return;
    end
    ce = m_car | p;
    hm = h;
    if (m_served != '0) begin
      hm[2*m_floor-1] = 1'b0;
      hm[2*m_floor-2] = 1'b0;
    end
    m_served = '0;
    case (m_mode)
      REST: begin
        m_car = ce;
        if (want(ce, hm, m_floor)) begin
          m_mode = DWELL; m_cnt = DT; m_door = 1; m_car[m_floor-1] = 1'b0;
          m_keep_up = 1; m_keep_dn = 1;
          m_served[2*m_floor-1] = 1'b1;
          m_served[2*m_floor-2] = 1'b1;
        end else begin
          ab = want_range(ce, hm, m_floor + 1, 7);
          bl = want_range(ce, hm, 1, m_floor - 1);
          if (ab || bl) begin
            m_dir  = (ab && bl) ? m_last : (ab ? 1 : -1);
            m_last = m_dir;
            m_mode = TRAVEL;
            m_cnt  = FT;
          end
        end
      end
      TRAVEL: begin
        m_car = ce;
        m_cnt--;
        if (m_cnt == 0) begin
          nf = m_floor + m_dir;
          if (nf > 7) nf = 7;
          if (nf < 1) nf = 1;
          m_floor = nf;
          beyond = (m_dir > 0) ? want_range(ce, hm, nf + 1, 7) : want_range(ce, hm, 1, nf - 1);
          hd  = (m_dir > 0) ? hm[2*nf-1] : hm[2*nf-2];
          lim = (m_dir > 0 && nf == 7) || (m_dir < 0 && nf == 1);
          if (ce[nf-1] || hd || (!beyond && want(ce, hm, nf)) || lim) begin
            m_mode = DWELL; m_cnt = DT; m_door = 1; m_car[nf-1] = 1'b0;
            m_keep_up = (m_dir > 0) || !beyond;
            m_keep_dn = (m_dir < 0) || !beyond;
            m_served[2*nf-1] = m_keep_up & hm[2*nf-1];
            m_served[2*nf-2] = m_keep_dn & hm[2*nf-2];
            if (!beyond) m_last = -m_dir;
          end else begin
            m_cnt = FT;
          end
        end
      end
      default: begin
        m_car = ce;
        m_car[m_floor-1] = 1'b0;
        hu  = m_keep_up & hm[2*m_floor-1];
        hdn = m_keep_dn & hm[2*m_floor-2];
        if (hu || hdn || p[m_floor-1]) begin
          m_cnt = DT;
          m_served[2*m_floor-1] = hu;
          m_served[2*m_floor-2] = hdn;
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_mode = REST; m_door = 0; m_dir = 0;
          end
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance model, dispatcher clears served calls, compare.
  task automatic tick();
    logic [13:0] sv_old;
    bus.hallButton     = hall_reg;
    bus.carButtonPress = press;
    reset              = rst_drv;
    sv_old = m_served;
    model_step(rst_drv, hall_reg, press);
    @(posedge clk);
    hall_reg = hall_reg & ~sv_old;
    press    = '0;
    @(negedge clk);
    check("floor",  32'(bus.currentFloor), 32'(m_floor));
    check("dir",    32'(bus.direction),    32'(dir_code(m_dir)));
    check("door",   32'(bus.doorOpen),     32'(m_door));
    check("carbtn", 32'(bus.carButton),    32'(m_car));
    check("served", 32'(bus.servedHall),   32'(m_served));
  endtask

  task automatic do_reset(input int n);
    rst_drv  = 1'b1;
    hall_reg = '0;
    repeat (n) tick();
    rst_drv  = 1'b0;
  endtask

  task automatic wait_door(input logic lvl, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (bus.doorOpen == lvl) break;
      tick();
    end
    check(tag, 32'(bus.doorOpen), 32'(lvl));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_drv = 1'b1; reset = 1'b1; hall_reg = '0; press = '0;
    bus.hallButton = '0; bus.carButtonPress = '0;
    model_step(1'b1, '0, '0);
    @(negedge clk);
    do_reset(2);
    check("rst_floor", 32'(bus.currentFloor), 32'd1);
    check("rst_dir",   32'(bus.direction),    32'd0);

    // T1: reset held 3 cycles while moving
    press = 7'b0100000;
    repeat (FT + 2) tick();
    check("t1_moving", 32'(bus.direction), 32'h2);
    do_reset(3);
    check("t1_floor",  32'(bus.currentFloor), 32'd1);
    check("t1_dir",    32'(bus.direction),    32'd0);
    check("t1_door",   32'(bus.doorOpen),     32'd0);
    check("t1_car",    32'(bus.carButton),    32'd0);
    check("t1_served", 32'(bus.servedHall),   32'd0);

    // T2: car press floor 5 from idle at 1
    press = 7'b0010000;
    tick();
    check("t2_dir_up", 32'(bus.direction), 32'h2);
    repeat (4*FT - 1) tick();
    check("t2_floor4", 32'(bus.currentFloor), 32'd4);
    tick();
    check("t2_floor5", 32'(bus.currentFloor), 32'd5);
    check("t2_door",   32'(bus.doorOpen),     32'd1);
    check("t2_car",    32'(bus.carButton),    32'd0);
    repeat (DT - 1) tick();
    check("t2_still_open", 32'(bus.doorOpen), 32'd1);
    tick();
    check("t2_closed", 32'(bus.doorOpen),  32'd0);
    check("t2_stop",   32'(bus.direction), 32'd0);

    // T3: pass floor-3 DOWN call going up, serve it on the way back
    do_reset(1);
    hall_reg = 14'h0010;
    press    = 7'b0100000;
    tick();
    wait_door(1'b1, "t3_open6");
    check("t3_floor6", 32'(bus.currentFloor), 32'd6);
    check("t3_dir6",   32'(bus.direction),    32'h2);
    wait_door(1'b0, "t3_close6");
    wait_door(1'b1, "t3_open3");
    check("t3_floor3",  32'(bus.currentFloor), 32'd3);
    check("t3_served3", 32'(bus.servedHall),   32'h0010);
    check("t3_dir3",    32'(bus.direction),    32'h1);
    tick();
    check("t3_pulse_end", 32'(bus.servedHall), 32'd0);

    // T4: hall UP at floor 4 while idle there
    do_reset(1);
    press = 7'b0001000;
    tick();
    wait_door(1'b1, "t4_open");
    wait_door(1'b0, "t4_close");
    hall_reg = 14'h0080;
    tick();
    check("t4_door",   32'(bus.doorOpen),   32'd1);
    check("t4_served", 32'(bus.servedHall), 32'h00C0);
    tick();
    check("t4_pulse_end", 32'(bus.servedHall), 32'd0);

    // T5: car press at current floor restarts door timer
    do_reset(1);
    press = 7'b0000010;
    tick();
    wait_door(1'b1, "t5_open");
    check("t5_floor2", 32'(bus.currentFloor), 32'd2);
    repeat (2) tick();
    press = 7'b0000010;
    tick();
    check("t5_not_latched", 32'(bus.carButton), 32'd0);
    repeat (DT - 1) tick();
    check("t5_held", 32'(bus.doorOpen), 32'd1);
    tick();
    check("t5_closed", 32'(bus.doorOpen), 32'd0);

    // T6: at top floor with a request at 1
    do_reset(1);
    press = 7'b1000000;
    tick();
    wait_door(1'b1, "t6_open7");
    check("t6_floor7", 32'(bus.currentFloor), 32'd7);
    wait_door(1'b0, "t6_close7");
    press = 7'b0000001;
    tick();
    check("t6_dir_down", 32'(bus.direction), 32'h1);
    wait_door(1'b1, "t6_open1");
    check("t6_floor1", 32'(bus.currentFloor), 32'd1);

    // random traffic
    do_reset(1);
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 39) == 0) hall_reg[$urandom_range(1, 12)] = 1'b1;
      if ($urandom_range(0, 59) == 0) press[$urandom_range(0, 6)] = 1'b1;
      rst_drv = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst_drv = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
